// File: rtl/spi_flash_responder.sv
// SPI mode-0 slave emulating the READ (0x03) path of a serial NOR flash.
// All SPI pins are oversampled in sys_clk; data comes from an external byte memory.
module spi_flash_responder #(
    parameter int          ADDR_W   = 24,
    parameter logic [7:0]  READ_CMD = 8'h03
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              spi_sclk,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              bad_cmd,
    output logic              xfer_done,
    output logic [15:0]       byte_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_IGNORE
    } state_t;

    state_t state_q, state_d;

    logic sclk_s1_q, sclk_s2_q, sclk_h_q;
    logic cs_s1_q, cs_s2_q, cs_h_q;
    logic mosi_s1_q, mosi_s2_q;
    logic [1:0] warm_q;

    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [22:0]       shift_q, shift_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [6:0]        tx_q, tx_d;
    logic              miso_q, miso_d;
    logic [15:0]       byte_cnt_q, byte_cnt_d;
    logic              rd_en_q, rd_en_d;
    logic              load_q, load_d;
    logic              bad_q, bad_d;
    logic              done_q, done_d;

    logic sclk_rise, sclk_fall, cs_fall, cs_rise, startup;
    logic [23:0] shift_in;

    // Synchronisers; CS resets high so reset itself never looks like a select.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_h_q  <= 1'b0;
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            cs_h_q    <= 1'b1;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            warm_q    <= 2'd0;
        end else begin
            sclk_s1_q <= spi_sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_h_q  <= sclk_s2_q;
            cs_s1_q   <= spi_cs;
            cs_s2_q   <= cs_s1_q;
            cs_h_q    <= cs_s2_q;
            mosi_s1_q <= spi_mosi;
            mosi_s2_q <= mosi_s1_q;
            if (warm_q != 2'd3)
                warm_q <= warm_q + 2'd1;
        end
    end

    assign sclk_rise = sclk_s2_q & ~sclk_h_q;
    assign sclk_fall = ~sclk_s2_q & sclk_h_q;
    assign cs_fall   = ~cs_s2_q & cs_h_q;
    assign cs_rise   = cs_s2_q & ~cs_h_q;
    // A CS fall seen while the synchroniser is still flushing reset values is
    // a transfer that started before reset; it must not be joined.
    assign startup   = (warm_q != 2'd3);
    assign shift_in  = {shift_q, mosi_s2_q};

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:
                if (cs_fall)
                    state_d = startup ? S_IGNORE : S_CMD;
            S_CMD:
                if (cs_rise)
                    state_d = S_IDLE;
                else if (sclk_rise && bit_cnt_q == 5'd7)
                    state_d = (shift_in[7:0] == READ_CMD) ? S_ADDR : S_IGNORE;
            S_ADDR:
                if (cs_rise)
                    state_d = S_IDLE;
                else if (sclk_rise && bit_cnt_q == 5'd23)
                    state_d = S_DATA;
            S_DATA, S_IGNORE:
                if (cs_rise)
                    state_d = S_IDLE;
            default:
                state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        mem_addr_d = mem_addr_q;
        tx_d       = tx_q;
        miso_d     = miso_q;
        byte_cnt_d = byte_cnt_q;
        rd_en_d    = 1'b0;
        load_d     = rd_en_q;
        bad_d      = 1'b0;
        done_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    bit_cnt_d  = 5'd0;
                    shift_d    = '0;
                    tx_d       = '0;
                    byte_cnt_d = 16'd0;
                end
            end
            S_CMD: begin
                if (cs_rise) begin
                    miso_d = 1'b0;
                end else if (sclk_rise) begin
                    shift_d   = shift_in[22:0];
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = 5'd0;
                        bad_d     = (shift_in[7:0] != READ_CMD);
                    end
                end
            end
            S_ADDR: begin
                if (cs_rise) begin
                    miso_d = 1'b0;
                end else if (sclk_rise) begin
                    shift_d   = shift_in[22:0];
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd23) begin
                        bit_cnt_d  = 5'd0;
                        addr_d     = shift_in[ADDR_W-1:0];
                        mem_addr_d = shift_in[ADDR_W-1:0];
                        rd_en_d    = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (cs_rise) begin
                    miso_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    if (load_q) begin
                        tx_d   = mem_rdata[6:0];
                        miso_d = mem_rdata[7];
                        addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end else if (sclk_fall && bit_cnt_q != 5'd0) begin
                        tx_d   = {tx_q[5:0], 1'b0};
                        miso_d = tx_q[6];
                    end
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        // Byte complete: count it and prefetch the next one.
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d  = 5'd0;
                            rd_en_d    = 1'b1;
                            mem_addr_d = addr_q;
                            if (byte_cnt_q != 16'hFFFF)
                                byte_cnt_d = byte_cnt_q + 16'd1;
                        end
                    end
                end
            end
            S_IGNORE: begin
                miso_d = 1'b0;
            end
            default: begin
                miso_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            bit_cnt_q  <= 5'd0;
            shift_q    <= '0;
            addr_q     <= '0;
            mem_addr_q <= '0;
            tx_q       <= '0;
            miso_q     <= 1'b0;
            byte_cnt_q <= 16'd0;
            rd_en_q    <= 1'b0;
            load_q     <= 1'b0;
            bad_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            mem_addr_q <= mem_addr_d;
            tx_q       <= tx_d;
            miso_q     <= miso_d;
            byte_cnt_q <= byte_cnt_d;
            rd_en_q    <= rd_en_d;
            load_q     <= load_d;
            bad_q      <= bad_d;
            done_q     <= done_d;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = ~cs_s2_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_addr    = mem_addr_q;
    assign bad_cmd     = bad_q;
    assign xfer_done   = done_q;
    assign byte_cnt    = byte_cnt_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: a 24-bit-address instance and an
// 8-bit-address instance share SCLK/MOSI but have separate chip selects.
module tb_spi_flash_responder;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        sclk, mosi, cs, cs8;
    logic        miso, miso_oe, rd_en, bad, done;
    logic [23:0] maddr;
    logic [7:0]  rdata;
    logic [15:0] bcnt;
    logic        miso8, miso_oe8, rd_en8, bad8, done8;
    logic [7:0]  maddr8;
    logic [7:0]  rdata8;
    logic [15:0] bcnt8;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    spi_flash_responder #(.ADDR_W(24), .READ_CMD(8'h03)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .spi_sclk(sclk), .spi_cs(cs),
        .spi_mosi(mosi), .spi_miso(miso), .spi_miso_oe(miso_oe),
        .mem_rd_en(rd_en), .mem_addr(maddr), .mem_rdata(rdata),
        .bad_cmd(bad), .xfer_done(done), .byte_cnt(bcnt)
    );

    spi_flash_responder #(.ADDR_W(8), .READ_CMD(8'h03)) dut8 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .spi_sclk(sclk), .spi_cs(cs8),
        .spi_mosi(mosi), .spi_miso(miso8), .spi_miso_oe(miso_oe8),
        .mem_rd_en(rd_en8), .mem_addr(maddr8), .mem_rdata(rdata8),
        .bad_cmd(bad8), .xfer_done(done8), .byte_cnt(bcnt8)
    );

    // Memory model: byte at address a is a[7:0] + 0x10, one-cycle read latency.
    always @(posedge sys_clk) begin
        if (rd_en)  rdata  <= maddr[7:0] + 8'h10;
        if (rd_en8) rdata8 <= maddr8 + 8'h10;
    end

    logic [23:0] rd_log  [0:255];
    logic [7:0]  rd8_log [0:255];
    int rd_cnt = 0, rd8_cnt = 0, done_cnt = 0, bad_cnt = 0, pulse_err = 0;
    logic rd_prev = 1'b0, rd8_prev = 1'b0, bad_prev = 1'b0, done_prev = 1'b0;

    always @(negedge sys_clk) begin
        if (rd_en) begin
            rd_log[rd_cnt % 256] = maddr;
            rd_cnt++;
        end
        if (rd_en8) begin
            rd8_log[rd8_cnt % 256] = maddr8;
            rd8_cnt++;
        end
        if (done) done_cnt++;
        if (bad) bad_cnt++;
        if ((rd_en && rd_prev) || (rd_en8 && rd8_prev) || (bad && bad_prev) || (done && done_prev))
            pulse_err++;
        rd_prev   = rd_en;
        rd8_prev  = rd_en8;
        bad_prev  = bad;
        done_prev = done;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic set_cs(input logic s8, input logic v);
        if (s8) cs8 = v;
        else    cs  = v;
    endtask

    // One mode-0 byte: MISO sampled just before each rising edge.
    task automatic spi_xfer(input logic s8, input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            tick(5);
            rx[i] = s8 ? miso8 : miso;
            sclk = 1'b1;
            tick(5);
            sclk = 1'b0;
        end
    endtask

    task automatic start_read(input logic s8, input logic [23:0] a);
        logic [7:0] rx;
        set_cs(s8, 1'b0);
        tick(5);
        spi_xfer(s8, 8'h03, rx);
        spi_xfer(s8, a[23:16], rx);
        spi_xfer(s8, a[15:8], rx);
        spi_xfer(s8, a[7:0], rx);
    endtask

    task automatic end_xfer(input logic s8);
        tick(5);
        set_cs(s8, 1'b1);
        tick(10);
    endtask

    task automatic test_reset;
        checks++; if (miso !== 1'b0)     begin errors++; $display("FAIL reset_miso got %0b want 0", miso); end
        checks++; if (miso_oe !== 1'b0)  begin errors++; $display("FAIL reset_oe got %0b want 0", miso_oe); end
        checks++; if (rd_en !== 1'b0)    begin errors++; $display("FAIL reset_rd_en got %0b want 0", rd_en); end
        checks++; if (maddr !== 24'h0)   begin errors++; $display("FAIL reset_addr got %h want 0", maddr); end
        checks++; if (bad !== 1'b0)      begin errors++; $display("FAIL reset_bad got %0b want 0", bad); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (bcnt !== 16'h0)    begin errors++; $display("FAIL reset_bcnt got %0d want 0", bcnt); end
    endtask

    task automatic test_basic_read;
        logic [7:0] rx;
        int r0, d0;
        r0 = rd_cnt; d0 = done_cnt;
        start_read(1'b0, 24'h000000);
        checks++; if (miso_oe !== 1'b1) begin errors++; $display("FAIL basic_oe got %0b want 1", miso_oe); end
        for (int i = 0; i < 10; i++) begin
            spi_xfer(1'b0, 8'h00, rx);
            checks++;
            if (rx !== 8'(8'h10 + i)) begin errors++; $display("FAIL basic_data[%0d] got %h want %h", i, rx, 8'(8'h10 + i)); end
        end
        end_xfer(1'b0);
        checks++; if (rd_cnt - r0 != 11) begin errors++; $display("FAIL basic_rd_count got %0d want 11", rd_cnt - r0); end
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (rd_log[(r0 + i) % 256] !== 24'(i)) begin errors++; $display("FAIL basic_rd_addr[%0d] got %h want %h", i, rd_log[(r0 + i) % 256], i); end
        end
        checks++; if (bcnt !== 16'd10)      begin errors++; $display("FAIL basic_bcnt got %0d want 10", bcnt); end
        checks++; if (done_cnt - d0 != 1)  begin errors++; $display("FAIL basic_done got %0d want 1", done_cnt - d0); end
        checks++; if (miso !== 1'b0)       begin errors++; $display("FAIL basic_miso_idle got %0b want 0", miso); end
        checks++; if (miso_oe !== 1'b0)    begin errors++; $display("FAIL basic_oe_idle got %0b want 0", miso_oe); end
    endtask

    task automatic test_addr_load;
        logic [7:0] rx0, rx1;
        int r0;
        r0 = rd_cnt;
        start_read(1'b0, 24'h010203);
        spi_xfer(1'b0, 8'h00, rx0);
        spi_xfer(1'b0, 8'h00, rx1);
        end_xfer(1'b0);
        checks++; if (rd_log[r0 % 256] !== 24'h010203)       begin errors++; $display("FAIL addr_first got %h want 010203", rd_log[r0 % 256]); end
        checks++; if (rd_log[(r0 + 1) % 256] !== 24'h010204) begin errors++; $display("FAIL addr_second got %h want 010204", rd_log[(r0 + 1) % 256]); end
        checks++; if (rx0 !== 8'h13) begin errors++; $display("FAIL addr_data0 got %h want 13", rx0); end
        checks++; if (rx1 !== 8'h14) begin errors++; $display("FAIL addr_data1 got %h want 14", rx1); end
    endtask

    task automatic test_wrap;
        logic [7:0] rx [3];
        logic [7:0] ea [3];
        logic [7:0] ed [3];
        int r0;
        ea = '{8'hFE, 8'hFF, 8'h00};
        ed = '{8'h0E, 8'h0F, 8'h10};
        r0 = rd8_cnt;
        start_read(1'b1, 24'h0000FE);
        for (int i = 0; i < 3; i++) spi_xfer(1'b1, 8'h00, rx[i]);
        end_xfer(1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd8_log[(r0 + i) % 256] !== ea[i]) begin errors++; $display("FAIL wrap_addr[%0d] got %h want %h", i, rd8_log[(r0 + i) % 256], ea[i]); end
            checks++;
            if (rx[i] !== ed[i]) begin errors++; $display("FAIL wrap_data[%0d] got %h want %h", i, rx[i], ed[i]); end
        end
        checks++; if (bcnt8 !== 16'd3) begin errors++; $display("FAIL wrap_bcnt got %0d want 3", bcnt8); end
    endtask

    task automatic test_bad_cmd;
        logic [7:0] rx;
        int r0, b0, d0;
        logic miso_seen;
        r0 = rd_cnt; b0 = bad_cnt; d0 = done_cnt;
        miso_seen = 1'b0;
        cs = 1'b0;
        tick(5);
        spi_xfer(1'b0, 8'h9F, rx);
        tick(2);
        checks++; if (bad_cnt - b0 != 1) begin errors++; $display("FAIL bad_pulse_after_cmd got %0d want 1", bad_cnt - b0); end
        for (int i = 0; i < 3; i++) begin
            spi_xfer(1'b0, 8'hA5, rx);
            if (rx !== 8'h00) miso_seen = 1'b1;
        end
        end_xfer(1'b0);
        checks++; if (bad_cnt - b0 != 1)  begin errors++; $display("FAIL bad_pulse_total got %0d want 1", bad_cnt - b0); end
        checks++; if (rd_cnt - r0 != 0)   begin errors++; $display("FAIL bad_no_fetch got %0d want 0", rd_cnt - r0); end
        checks++; if (miso_seen !== 1'b0) begin errors++; $display("FAIL bad_miso_quiet got %0b want 0", miso_seen); end
        checks++; if (done_cnt - d0 != 0) begin errors++; $display("FAIL bad_no_done got %0d want 0", done_cnt - d0); end
    endtask

    task automatic test_abort;
        logic [7:0] rx;
        int r0, d0;
        r0 = rd_cnt; d0 = done_cnt;
        start_read(1'b0, 24'h000000);
        spi_xfer(1'b0, 8'h00, rx);
        checks++; if (rx !== 8'h10) begin errors++; $display("FAIL abort_byte0 got %h want 10", rx); end
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b0;
            tick(5);
            sclk = 1'b1;
            tick(5);
            sclk = 1'b0;
        end
        tick(5);
        // Byte 0x11 after three shifts presents bit 4, which is 1.
        checks++; if (miso !== 1'b1) begin errors++; $display("FAIL abort_miso_before got %0b want 1", miso); end
        cs = 1'b1;
        tick(4);
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL abort_miso_after got %0b want 0", miso); end
        tick(20);
        checks++; if (bcnt !== 16'd1)      begin errors++; $display("FAIL abort_bcnt got %0d want 1", bcnt); end
        checks++; if (done_cnt - d0 != 1)  begin errors++; $display("FAIL abort_done got %0d want 1", done_cnt - d0); end
        checks++; if (rd_cnt - r0 != 2)    begin errors++; $display("FAIL abort_fetches got %0d want 2", rd_cnt - r0); end
        start_read(1'b0, 24'h000005);
        spi_xfer(1'b0, 8'h00, rx);
        end_xfer(1'b0);
        checks++; if (rx !== 8'h15)   begin errors++; $display("FAIL abort_restart_data got %h want 15", rx); end
        checks++; if (bcnt !== 16'd1) begin errors++; $display("FAIL abort_restart_bcnt got %0d want 1", bcnt); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] rx0, rx1;
        int r0;
        cs = 1'b0;
        tick(5);
        spi_xfer(1'b0, 8'h03, rx0);
        spi_xfer(1'b0, 8'h00, rx0);
        sys_rst = 1'b1;
        tick(3);
        checks++; if (maddr !== 24'h0)  begin errors++; $display("FAIL rmid_addr got %h want 0", maddr); end
        checks++; if (bcnt !== 16'h0)   begin errors++; $display("FAIL rmid_bcnt got %0d want 0", bcnt); end
        checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL rmid_oe got %0b want 0", miso_oe); end
        sys_rst = 1'b0;
        tick(4);
        checks++; if (miso_oe !== 1'b1) begin errors++; $display("FAIL rmid_oe_follow got %0b want 1", miso_oe); end
        r0 = rd_cnt;
        spi_xfer(1'b0, 8'h00, rx0);
        spi_xfer(1'b0, 8'h20, rx0);
        spi_xfer(1'b0, 8'h00, rx0);
        spi_xfer(1'b0, 8'h00, rx1);
        checks++; if (rd_cnt - r0 != 0)           begin errors++; $display("FAIL rmid_ignored_fetch got %0d want 0", rd_cnt - r0); end
        checks++; if ({rx0, rx1} !== 16'h0000)   begin errors++; $display("FAIL rmid_ignored_miso got %h want 0000", {rx0, rx1}); end
        end_xfer(1'b0);
        start_read(1'b0, 24'h000020);
        spi_xfer(1'b0, 8'h00, rx0);
        spi_xfer(1'b0, 8'h00, rx1);
        end_xfer(1'b0);
        checks++; if (rx0 !== 8'h30)  begin errors++; $display("FAIL rmid_data0 got %h want 30", rx0); end
        checks++; if (rx1 !== 8'h31)  begin errors++; $display("FAIL rmid_data1 got %h want 31", rx1); end
        checks++; if (bcnt !== 16'd2) begin errors++; $display("FAIL rmid_bcnt_after got %0d want 2", bcnt); end
    endtask

    initial begin
        sys_rst = 1'b1;
        cs      = 1'b1;
        cs8     = 1'b1;
        sclk    = 1'b0;
        mosi    = 1'b0;
        tick(3);
        test_reset;
        sys_rst = 1'b0;
        tick(8);
        test_basic_read;
        test_addr_load;
        test_wrap;
        test_bad_cmd;
        test_abort;
        test_reset_mid;
        checks++; if (pulse_err != 0) begin errors++; $display("FAIL pulse_width got %0d want 0", pulse_err); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
